// File: rtl/fifo_ext.sv
// fifo_ext: synchronous single-clock FIFO with occupancy count, almost-full /
// almost-empty thresholds, registered read data and a synchronous flush.
// Optional sticky overflow/underflow flags are built only when the macro
// FIFO_EXT_ERR_FLAGS_EN is defined; otherwise those ports are tied to 0.
module fifo_ext #(
  parameter int WordLength     = 8,
  parameter int AddrBits       = 4,
  parameter int AlmostFullThr  = 2**AddrBits - 2,
  parameter int AlmostEmptyThr = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic [WordLength-1:0] w_data_i,
  output logic [WordLength-1:0] r_data_o,
  output logic [AddrBits:0]     count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_empty_o,
  output logic                  almost_full_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int Depth = 2**AddrBits;

  // Thresholds and the full level, sized to the count register.
  localparam logic [AddrBits:0] DepthC = {1'b1, {AddrBits{1'b0}}};
  localparam logic [AddrBits:0] AfThrC = AlmostFullThr[AddrBits:0];
  localparam logic [AddrBits:0] AeThrC = AlmostEmptyThr[AddrBits:0];

  logic [WordLength-1:0] mem_q [Depth];

  logic [AddrBits-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrBits-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AddrBits:0]     count_q,  count_d;
  logic [WordLength-1:0] r_data_q, r_data_d;

  logic                  rd_acc;
  logic                  wr_acc;

  // Status flags come straight from the registered count.
  assign empty_o        = (count_q == {(AddrBits+1){1'b0}});
  assign full_o         = (count_q == DepthC);
  assign almost_full_o  = (count_q >= AfThrC);
  assign almost_empty_o = (count_q <= AeThrC);
  assign count_o        = count_q;
  assign r_data_o       = r_data_q;

  // A read needs data; a write needs room, or a same-cycle read that frees a slot.
  assign rd_acc = rd_i & ~empty_o;
  assign wr_acc = wr_i & (~full_o | rd_acc);

  // Next-state for pointers, occupancy and read data; flush overrides traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    r_data_d = r_data_q;
    if (clr_i) begin
      wr_ptr_d = {AddrBits{1'b0}};
      rd_ptr_d = {AddrBits{1'b0}};
      count_d  = {(AddrBits+1){1'b0}};
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + AddrBits'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + AddrBits'(1);
        r_data_d = mem_q[rd_ptr_q];
      end else begin
        rd_ptr_d = rd_ptr_q;
        r_data_d = r_data_q;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + (AddrBits+1)'(1);
        2'b01:   count_d = count_q - (AddrBits+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, count and read-data registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AddrBits{1'b0}};
      rd_ptr_q <= {AddrBits{1'b0}};
      count_q  <= {(AddrBits+1){1'b0}};
      r_data_q <= {WordLength{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      r_data_q <= r_data_d;
    end
  end

  // Storage array: written only on an accepted write outside a flush, never reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc && !clr_i) begin
      mem_q[wr_ptr_q] <= w_data_i;
    end
  end

`ifdef FIFO_EXT_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags: a rejected write, or a read of an empty FIFO with no write.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      ovf_d = ovf_q | (wr_i & ~wr_acc);
      udf_d = udf_q | (rd_i & empty_o & ~wr_i);
    end
  end

  // Error flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ext.sv
// tb_fifo_ext: directed self-checking bench for fifo_ext at depth 4.
module tb_fifo_ext;

`ifdef FIFO_EXT_ERR_FLAGS_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       clr_i = 1'b0;
  logic       wr_i  = 1'b0;
  logic       rd_i  = 1'b0;
  logic [7:0] w_data_i = 8'h00;
  logic [7:0] r_data_o;
  logic [2:0] count_o;
  logic       empty_o, full_o, almost_empty_o, almost_full_o;
  logic       overflow_o, underflow_o;

  int n_cmp = 0;
  int n_err = 0;

  fifo_ext #(
    .WordLength(8), .AddrBits(2), .AlmostFullThr(3), .AlmostEmptyThr(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .wr_i(wr_i), .rd_i(rd_i),
    .w_data_i(w_data_i), .r_data_o(r_data_o), .count_o(count_o),
    .empty_o(empty_o), .full_o(full_o), .almost_empty_o(almost_empty_o),
    .almost_full_o(almost_full_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request; inputs return to idle #1 after the edge.
  task automatic cyc(input logic wr, input logic rd, input logic [7:0] d, input logic clr);
    wr_i = wr; rd_i = rd; w_data_i = d; clr_i = clr;
    @(posedge clk_i);
    #1;
    wr_i = 1'b0; rd_i = 1'b0; w_data_i = 8'h00; clr_i = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".count"},  32'(count_o), 32'd0);
    check_eq({tag, ".rdata"},  32'(r_data_o), 32'h00);
    check_eq({tag, ".empty"},  32'(empty_o), 32'd1);
    check_eq({tag, ".full"},   32'(full_o), 32'd0);
    check_eq({tag, ".aempty"}, 32'(almost_empty_o), 32'd1);
    check_eq({tag, ".afull"},  32'(almost_full_o), 32'd0);
    check_eq({tag, ".ovf"},    32'(overflow_o), 32'd0);
    check_eq({tag, ".udf"},    32'(underflow_o), 32'd0);
  endtask

  // Interleaved wrap vectors: {wr, rd, wdata, expected count, expected r_data}
  logic [7:0] wv_wr   [8] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0};
  logic [7:0] wv_rd   [8] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
  logic [7:0] wv_dat  [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h00, 8'h00};
  logic [7:0] wv_cnt  [8] = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd0};
  logic [7:0] wv_rdat [8] = '{8'h77, 8'h77, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

  initial begin
    logic [7:0] fill [4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

    #1;
    check_reset_state("rst");
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Fill to full, watching count and threshold flags.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, fill[i], 1'b0);
      check_eq("fill.count", 32'(count_o), 32'(i + 1));
      check_eq("fill.afull", 32'(almost_full_o), (i + 1 >= 3) ? 32'd1 : 32'd0);
      check_eq("fill.aempty", 32'(almost_empty_o), (i + 1 <= 1) ? 32'd1 : 32'd0);
      check_eq("fill.full", 32'(full_o), (i + 1 == 4) ? 32'd1 : 32'd0);
    end
    check_eq("fill.rdata_hold", 32'(r_data_o), 32'h00);

    // Write into a full FIFO: rejected, overflow latches.
    cyc(1'b1, 1'b0, 8'h55, 1'b0);
    check_eq("ovf.count", 32'(count_o), 32'd4);
    check_eq("ovf.flag", 32'(overflow_o), 32'(ErrEn));
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("ovf.sticky", 32'(overflow_o), 32'(ErrEn));

    // Full with simultaneous read and write.
    cyc(1'b1, 1'b1, 8'h66, 1'b0);
    check_eq("rw_full.rdata", 32'(r_data_o), 32'h11);
    check_eq("rw_full.count", 32'(count_o), 32'd4);

    // Drain: 0x55 must be absent, 0x66 last.
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("drain0", 32'(r_data_o), 32'h22);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("drain1", 32'(r_data_o), 32'h33);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("drain2", 32'(r_data_o), 32'h44);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("drain3", 32'(r_data_o), 32'h66);
    check_eq("drain.empty", 32'(empty_o), 32'd1);
    check_eq("drain.count", 32'(count_o), 32'd0);

    // Read of an empty FIFO.
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("udf.flag", 32'(underflow_o), 32'(ErrEn));
    check_eq("udf.rdata", 32'(r_data_o), 32'h66);
    check_eq("udf.count", 32'(count_o), 32'd0);

    // Empty with both requests: only the write lands.
    cyc(1'b1, 1'b1, 8'h77, 1'b0);
    check_eq("erw.count", 32'(count_o), 32'd1);
    check_eq("erw.rdata", 32'(r_data_o), 32'h66);
    check_eq("erw.udf", 32'(underflow_o), 32'(ErrEn));
    check_eq("erw.ovf", 32'(overflow_o), 32'(ErrEn));
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("erw.read", 32'(r_data_o), 32'h77);

    // Interleaved writes/reads across pointer wraps.
    for (int i = 0; i < 8; i++) begin
      cyc(wv_wr[i][0], wv_rd[i][0], wv_dat[i], 1'b0);
      check_eq($sformatf("wrap%0d.count", i), 32'(count_o), 32'(wv_cnt[i]));
      check_eq($sformatf("wrap%0d.rdata", i), 32'(r_data_o), 32'(wv_rdat[i]));
    end

    // Build count 3 with overflow set, then flush (with a write that must be ignored).
    cyc(1'b1, 1'b0, 8'hB0, 1'b0);
    cyc(1'b1, 1'b0, 8'hB1, 1'b0);
    cyc(1'b1, 1'b0, 8'hB2, 1'b0);
    cyc(1'b1, 1'b0, 8'hB3, 1'b0);
    cyc(1'b1, 1'b0, 8'hB4, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("pre_clr.count", 32'(count_o), 32'd3);
    check_eq("pre_clr.rdata", 32'(r_data_o), 32'hB0);
    check_eq("pre_clr.ovf", 32'(overflow_o), 32'(ErrEn));
    cyc(1'b1, 1'b0, 8'hEE, 1'b1);
    check_eq("clr.count", 32'(count_o), 32'd0);
    check_eq("clr.empty", 32'(empty_o), 32'd1);
    check_eq("clr.ovf", 32'(overflow_o), 32'd0);
    check_eq("clr.udf", 32'(underflow_o), 32'd0);
    check_eq("clr.rdata", 32'(r_data_o), 32'hB0);

    // Pointers restart at zero after flush.
    cyc(1'b1, 1'b0, 8'hC0, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("post_clr.rdata", 32'(r_data_o), 32'hC0);

    // Asynchronous reset mid-stream, checked before the next edge.
    cyc(1'b1, 1'b0, 8'hC1, 1'b0);
    cyc(1'b1, 1'b0, 8'hC2, 1'b0);
    rst_i = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cyc(1'b1, 1'b0, 8'hD0, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("post_rst.rdata", 32'(r_data_o), 32'hD0);
    check_eq("post_rst.count", 32'(count_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1);
  end

endmodule
